alu_operand_stage: RTL
======================

Name: alu_operand_stage

Overview:
- Pipeline register stage directly upstream of the ALU.
- Captures decoded instruction fields and register-file read data, and resolves operand forwarding from the EX and WB stages.
- Selects immediate vs register for operand b, and presents registered a, b and alucont to the ALU.
- Provides a valid/ready handshake on both sides, plus load-use stall and flush.

Parameters:
- WIDTH, 32, datapath width of a, b and forwarded data.
- AW, 5, register address width.

Ports:
- clk  input  1  clock; rising edge.
- reset_n  input  1  asynchronous reset, active low.
- flush  input  1  synchronous squash of the held entry and of the current input.
- in_valid  input  1  upstream presents an instruction.
- in_ready  output  1  stage accepts the input this cycle.
- rs_addr  input  AW  source register 1 index.
- rt_addr  input  AW  source register 2 index.
- rs_data  input  WIDTH  register-file read data for rs.
- rt_data  input  WIDTH  register-file read data for rt.
- imm  input  16  instruction immediate.
- use_imm  input  1  b comes from the extended immediate instead of rt.
- sign_ext  input  1  1 = sign-extend imm, 0 = zero-extend imm.
- alucont_in  input  6  ALU control code; bit 5 = subtract, [4:0] = operation.
- dest_addr  input  AW  destination register.
- dest_we  input  1  instruction writes dest_addr.
- is_load  input  1  instruction is a load.
- ex_fwd_we  input  1  EX-stage instruction writes a register.
- ex_fwd_addr  input  AW  EX-stage destination.
- ex_fwd_data  input  WIDTH  EX-stage result.
- ex_fwd_load  input  1  EX-stage instruction is a load; its data is not yet available.
- wb_fwd_we  input  1  WB-stage write enable.
- wb_fwd_addr  input  AW  WB-stage destination.
- wb_fwd_data  input  WIDTH  WB-stage write data.
- out_valid  output  1  a, b and alucont are valid for the ALU.
- out_ready  input  1  downstream consumes the entry this cycle.
- a  output  WIDTH  ALU operand a, registered.
- b  output  WIDTH  ALU operand b, registered.
- alucont  output  6  ALU control, registered.
- out_dest_addr  output  AW  registered dest_addr.
- out_dest_we  output  1  registered dest_we.
- out_is_load  output  1  registered is_load.

Behaviour:
- Reset: asynchronous on reset_n low. All outputs are 0: out_valid=0, a=0, b=0, alucont=0, out_dest_addr=0, out_dest_we=0, out_is_load=0. A reset mid-stall drops the held entry.
- Single-entry register; latency 1 cycle from accept to out_valid.
- Hazard: hazard = in_valid & ex_fwd_we & ex_fwd_load & ex_fwd_addr!=0 & (ex_fwd_addr==rs_addr | (~use_imm & ex_fwd_addr==rt_addr)).
- in_ready = (~out_valid | out_ready) & ~hazard. This is combinational; in_ready does not depend on in_valid except through hazard.
- Accept when in_valid & in_ready & ~flush: load all output registers and set out_valid=1.
- No accept & out_ready: out_valid <= 0.
- No accept & ~out_ready: hold all output registers unchanged. Operands do not change while out_valid=1 and out_ready=0.
- flush=1: out_valid <= 0 next cycle and the input is not captured, regardless of out_ready or hazard. Data registers may retain old values.
- Operand resolve, per source X in {rs, rt}:
  - X_addr==0 -> value 0, no forwarding, and the register-file data is ignored.
  - Else if ex_fwd_we & ~ex_fwd_load & ex_fwd_addr==X_addr -> ex_fwd_data.
  - Else if wb_fwd_we & wb_fwd_addr==X_addr -> wb_fwd_data.
  - Else -> register-file data.
  - EX has priority over WB.
- b: use_imm=1 -> immediate extended to WIDTH (sign or zero per sign_ext); else resolved rt.
- alucont <= alucont_in unchanged.
- Hazard while the held entry drains: out_valid falls to 0 after consumption. This inserts a bubble; in_ready stays 0 until ex_fwd_load deasserts or the address no longer matches.
- Simultaneous out_ready & accept: the new entry replaces the old one with no bubble.

Optional Feature:
- Macro STALL_COUNT_EN.
- Defined: adds output port stall_count (32 bits). It is reset to 0 and increments by 1 on every cycle with in_valid & ~in_ready & ~flush. It saturates at 0xFFFFFFFF and is not cleared by flush.
- Undefined: no port and no counter logic; all other behaviour is identical.

Test Plan:
- Reset: after reset_n low then high, all outputs are 0. Then rs=3 (data 0x5), rt=4 (data 0x7), alucont_in=6'b000010, use_imm=0 -> next cycle out_valid=1, a=0x5, b=0x7, alucont=0x02.
- Immediate: imm=0xFFFC, use_imm=1, sign_ext=1 -> b=0xFFFFFFFC. With sign_ext=0 -> b=0x0000FFFC.
- Forwarding:
  - rs=8, ex_fwd_we=1, ex_fwd_addr=8, ex_fwd_data=0xAA, wb_fwd_addr=8, wb_fwd_data=0xBB -> a=0xAA.
  - With ex_fwd_we=0 -> a=0xBB.
  - rs=0 with all forwards targeting 0 -> a=0.
- Load-use: ex_fwd_load=1, ex_fwd_addr=rt=9, use_imm=0, in_valid=1 -> in_ready=0 for 2 cycles while ex_fwd_load is held. Release -> accepted the next cycle. With STALL_COUNT_EN, stall_count=2.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, and a, b, alucont stable. Then out_ready=1 -> the new entry loads the same cycle with no bubble.
- Flush: flush=1 while out_valid=1 and in_valid=1 -> next cycle out_valid=0 and the input is discarded. The following cycle accepts normally.

Source files
------------

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: single-entry pipeline register directly ahead of the ALU.
// Resolves rs/rt operands with EX-over-WB forwarding, picks immediate or rt
// for operand b, and stalls the front end on a load-use hazard.
// Handshake is valid/ready on both sides; flush squashes the held entry and
// the current input.
// Optional feature: define STALL_COUNT_EN to add the 32-bit stall_count port,
// a saturating count of cycles where input was offered but refused.

module alu_operand_stage #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [AW-1:0]    rs_addr,
    input  logic [AW-1:0]    rt_addr,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic [15:0]      imm,
    input  logic             use_imm,
    input  logic             sign_ext,
    input  logic [5:0]       alucont_in,
    input  logic [AW-1:0]    dest_addr,
    input  logic             dest_we,
    input  logic             is_load,
    input  logic             ex_fwd_we,
    input  logic [AW-1:0]    ex_fwd_addr,
    input  logic [WIDTH-1:0] ex_fwd_data,
    input  logic             ex_fwd_load,
    input  logic             wb_fwd_we,
    input  logic [AW-1:0]    wb_fwd_addr,
    input  logic [WIDTH-1:0] wb_fwd_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [5:0]       alucont,
    output logic [AW-1:0]    out_dest_addr,
    output logic             out_dest_we,
    output logic             out_is_load
`ifdef STALL_COUNT_EN
    ,
    output logic [31:0]      stall_count
`endif
);

    logic             hazard;
    logic             accept;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic [WIDTH-1:0] imm_ext;
    logic [WIDTH-1:0] b_next;

    // Load-use hazard: the EX load's result is not ready yet, so an instruction
    // reading that register must wait. Register 0 never creates a dependency.
    always_comb begin
        hazard = in_valid & ex_fwd_we & ex_fwd_load & (ex_fwd_addr != '0) &
                 ((ex_fwd_addr == rs_addr) | (~use_imm & (ex_fwd_addr == rt_addr)));
    end

    // Accept when the slot is empty or draining this cycle and no hazard blocks it.
    always_comb begin
        in_ready = (~out_valid | out_ready) & ~hazard;
        accept   = in_valid & in_ready & ~flush;
    end

    // Operand rs: r0 reads as zero, then EX result (non-load), then WB data, then regfile.
    always_comb begin
        rs_val = rs_data;
        if (rs_addr == '0) begin
            rs_val = '0;
        end else if (ex_fwd_we & ~ex_fwd_load & (ex_fwd_addr == rs_addr)) begin
            rs_val = ex_fwd_data;
        end else if (wb_fwd_we & (wb_fwd_addr == rs_addr)) begin
            rs_val = wb_fwd_data;
        end
    end

    // Operand rt: same priority as rs.
    always_comb begin
        rt_val = rt_data;
        if (rt_addr == '0) begin
            rt_val = '0;
        end else if (ex_fwd_we & ~ex_fwd_load & (ex_fwd_addr == rt_addr)) begin
            rt_val = ex_fwd_data;
        end else if (wb_fwd_we & (wb_fwd_addr == rt_addr)) begin
            rt_val = wb_fwd_data;
        end
    end

    // Operand b: extended immediate or resolved rt.
    always_comb begin
        imm_ext = sign_ext ? {{(WIDTH-16){imm[15]}}, imm} : {{(WIDTH-16){1'b0}}, imm};
        b_next  = use_imm ? imm_ext : rt_val;
    end

    // Output register: flush empties, accept loads, consumption without refill
    // empties, otherwise everything is held so the ALU sees stable operands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid     <= 1'b0;
            a             <= '0;
            b             <= '0;
            alucont       <= '0;
            out_dest_addr <= '0;
            out_dest_we   <= 1'b0;
            out_is_load   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            a             <= rs_val;
            b             <= b_next;
            alucont       <= alucont_in;
            out_dest_addr <= dest_addr;
            out_dest_we   <= dest_we;
            out_is_load   <= is_load;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef STALL_COUNT_EN
    // Count refused-input cycles, saturating; flush does not clear it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= '0;
        end else if (in_valid & ~in_ready & ~flush & (stall_count != 32'hFFFF_FFFF)) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule
